// File: rtl/ram_handshake_pkg.sv
// Shared definitions for the MOV/MOC handshake RAM: FSM encoding, RW polarity, wait limits.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ram_handshake_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Wait counter is 4 bits wide, so WAIT_CYCLES may range 0..15.
    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 15;

endpackage

// File: rtl/ram_byte_array.sv
// Byte-addressed storage with a synchronous 32-bit big-endian word read/write port.
// Latency: write commits and read data registers on the edge where en is high.
// Backpressure: none; the caller sequences en/we, so every enabled access completes.
module ram_byte_array #(
    parameter int ADDR_W = 9
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-3:0] word_addr,
    input  logic [31:0]       wr_dat,
    output logic [31:0]       rd_dat
);

    // Sized exactly to 2**ADDR_W bytes, so an aligned word never crosses the end.
    logic [7:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] byte0_addr;
    logic [ADDR_W-1:0] byte1_addr;
    logic [ADDR_W-1:0] byte2_addr;
    logic [ADDR_W-1:0] byte3_addr;

    assign byte0_addr = {word_addr, 2'd0};
    assign byte1_addr = {word_addr, 2'd1};
    assign byte2_addr = {word_addr, 2'd2};
    assign byte3_addr = {word_addr, 2'd3};

    // Storage is intentionally not reset; lowest byte address carries the MSB.
    always_ff @(posedge Clk) begin
        if (en && we) begin
            mem[byte0_addr] <= wr_dat[31:24];
            mem[byte1_addr] <= wr_dat[23:16];
            mem[byte2_addr] <= wr_dat[15:8];
            mem[byte3_addr] <= wr_dat[7:0];
        end
    end

    // Read data register: cleared by reset, updated only by reads, held across writes.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_dat <= '0;
        end else if (en && !we) begin
            rd_dat <= {mem[byte0_addr], mem[byte1_addr], mem[byte2_addr], mem[byte3_addr]};
        end
    end

endmodule

// File: rtl/ram_handshake.sv
// Word RAM behind a MOV/MOC handshake: capture on MOV, wait WAIT_CYCLES, access, raise MOC.
// Latency: MOC rises WAIT_CYCLES+1 edges after the capture edge; DataOut is valid with it.
// Backpressure: MOC is held while MOV stays high; a new access needs MOV low for one edge.
import ram_handshake_pkg::*;

module ram_handshake #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MOV,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              capture;
    logic              access_en;
    logic              rw_q;
    logic [ADDR_W-3:0] waddr_q;
    logic [31:0]       wdat_q;
    logic              moc_q;

    // Byte lanes within a word are not selectable; accesses are always word-aligned.
    logic [1:0] unused_addr_lsb;
    assign unused_addr_lsb = Address[1:0];

    // Next-state logic: capture in IDLE, count down in BUSY, wait for MOV low in DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        access_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (MOV) begin
                    capture = 1'b1;
                    cnt_d   = WAIT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    access_en = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (!MOV) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and MOC registers; MOC mirrors the registered DONE state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            moc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            moc_q   <= (state_d == DONE);
        end
    end

    // Request capture; inputs are free to change once the access is in flight.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rw_q    <= RW_READ;
            waddr_q <= '0;
            wdat_q  <= '0;
        end else if (capture) begin
            rw_q    <= RW;
            waddr_q <= Address[ADDR_W-1:2];
            wdat_q  <= DataIn;
        end
    end

    ram_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .Clk       (Clk),
        .Reset     (Reset),
        .en        (access_en),
        .we        (rw_q == RW_WRITE),
        .word_addr (waddr_q),
        .wr_dat    (wdat_q),
        .rd_dat    (DataOut)
    );

    assign MOC = moc_q;

endmodule

// File: tb/tb_ram_handshake.sv
// Bench for ram_handshake: directed handshake scenarios plus randomized traffic vs a byte model.
// Two instances: WAIT_CYCLES=2 (index 0) and WAIT_CYCLES=0 (index 1).
// Outputs are sampled #1 after the rising edge or on the falling edge.
module tb_ram_handshake;

    logic        Clk;
    logic        Reset;
    logic        mov  [2];
    logic        rw   [2];
    logic [8:0]  addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        moc  [2];

    int tests;
    int fails;

    // Reference: plain byte array per instance plus the expected DataOut register.
    logic [7:0]  mm      [2][512];
    logic [31:0] exp_dout[2];
    int          lat_exp [2];

    ram_handshake #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .MOV(mov[0]), .RW(rw[0]), .Address(addr[0]),
        .DataIn(din[0]), .DataOut(dout[0]), .MOC(moc[0])
    );

    ram_handshake #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .MOV(mov[1]), .RW(rw[1]), .Address(addr[1]),
        .DataIn(din[1]), .DataOut(dout[1]), .MOC(moc[1])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int inst, input logic [8:0] a);
        int b;
        b = int'(a) & ~3;
        return {mm[inst][b], mm[inst][b+1], mm[inst][b+2], mm[inst][b+3]};
    endfunction

    task automatic model_write(input int inst, input logic [8:0] a, input logic [31:0] d);
        int b;
        b = int'(a) & ~3;
        mm[inst][b]   = d[31:24];
        mm[inst][b+1] = d[23:16];
        mm[inst][b+2] = d[15:8];
        mm[inst][b+3] = d[7:0];
    endtask

    // One full handshake. hold = cycles MOV stays high after MOC; early = drop MOV right after capture.
    task automatic access(input int inst, input bit rd, input logic [8:0] a, input logic [31:0] d,
                          input int hold, input bit early);
        int n;
        @(negedge Clk);
        mov[inst] = 1'b1;
        rw[inst]  = rd;
        addr[inst] = a;
        din[inst]  = d;
        @(posedge Clk);               // capture edge
        @(negedge Clk);
        addr[inst] = 9'($urandom);    // request is already latched
        din[inst]  = $urandom;
        rw[inst]   = 1'($urandom);
        if (early) mov[inst] = 1'b0;
        n = 0;
        while (moc[inst] !== 1'b1 && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("moc_latency", 32'(n), 32'(lat_exp[inst]));
        if (rd) exp_dout[inst] = model_read(inst, a);
        else    model_write(inst, a, d);
        check(rd ? "read_data" : "dout_held_on_write", dout[inst], exp_dout[inst]);
        if (early) begin
            @(posedge Clk);
            #1;
            check("moc_one_cycle_pulse", 32'(moc[inst]), 32'd0);
        end else begin
            for (int k = 0; k < hold; k++) begin
                @(posedge Clk);
                #1;
                check("moc_held", 32'(moc[inst]), 32'd1);
                check("dout_stable_held", dout[inst], exp_dout[inst]);
            end
            @(negedge Clk);
            mov[inst] = 1'b0;
            @(posedge Clk);
            #1;
            check("moc_fall", 32'(moc[inst]), 32'd0);
        end
    endtask

    initial begin
        logic [8:0]  pool [8];
        logic [31:0] old_020;
        tests = 0;
        fails = 0;
        lat_exp[0] = 3;
        lat_exp[1] = 1;
        for (int i = 0; i < 2; i++) begin
            mov[i] = 1'b0; rw[i] = 1'b1; addr[i] = '0; din[i] = '0;
            exp_dout[i] = '0;
        end

        // Power-on reset
        Reset = 1'b0;
        #1;
        check("rst_moc", 32'(moc[0]), 32'd0);
        check("rst_dout", dout[0], 32'd0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;

        // Write then read, alignment, held MOV
        access(0, 1'b0, 9'h010, 32'hE0811002, 0, 1'b0);
        access(0, 1'b1, 9'h010, 32'h0, 0, 1'b0);
        check("read_E0811002", dout[0], 32'hE0811002);
        check("byte_010", 32'(dut.u_mem.mem[16]), 32'hE0);
        check("byte_013", 32'(dut.u_mem.mem[19]), 32'h02);
        access(0, 1'b1, 9'h013, 32'h0, 5, 1'b0);
        check("aligned_read", dout[0], 32'hE0811002);

        // Early drop of MOV during a write, then read it back
        access(0, 1'b0, 9'h044, 32'hA5A55A5A, 0, 1'b1);
        access(0, 1'b1, 9'h044, 32'h0, 0, 1'b0);
        check("early_drop_commit", dout[0], 32'hA5A55A5A);

        // Zero wait-state instance
        access(1, 1'b0, 9'h1FC, 32'h12345678, 0, 1'b0);
        access(1, 1'b1, 9'h1FF, 32'h0, 2, 1'b0);
        check("top_word_read", dout[1], 32'h12345678);
        access(1, 1'b0, 9'h008, 32'hCAFEF00D, 0, 1'b1);

        // Reset abort: old contents at 0x020 survive an interrupted write
        old_020 = 32'h11223344;
        access(0, 1'b0, 9'h020, old_020, 0, 1'b0);
        @(negedge Clk);
        mov[0] = 1'b1; rw[0] = 1'b0; addr[0] = 9'h020; din[0] = 32'hDEADBEEF;
        @(posedge Clk);               // capture, now BUSY
        @(negedge Clk);
        Reset = 1'b0;
        mov[0] = 1'b0;
        #1;
        check("abort_rst_moc", 32'(moc[0]), 32'd0);
        check("abort_rst_dout", dout[0], 32'd0);
        check("abort_rst_dout_i1", dout[1], 32'd0);
        exp_dout[0] = '0;
        exp_dout[1] = '0;
        @(negedge Clk);
        Reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge Clk);
            #1;
            check("abort_moc_quiet", 32'(moc[0]), 32'd0);
        end
        access(0, 1'b1, 9'h020, 32'h0, 0, 1'b0);
        check("abort_old_contents", dout[0], old_020);

        // Randomized traffic on both instances over a pool including the top word
        for (int inst = 0; inst < 2; inst++) begin
            pool[0] = 9'h1FC;
            pool[1] = 9'h000;
            for (int i = 2; i < 8; i++) pool[i] = 9'($urandom) & 9'h1FC;
            for (int i = 0; i < 8; i++) access(inst, 1'b0, pool[i], $urandom, 0, 1'b0);
            for (int i = 0; i < 16; i++) begin
                logic [8:0] a;
                a = pool[$urandom_range(0, 7)] | 9'($urandom_range(0, 3));
                access(inst, 1'($urandom), a, $urandom, $urandom_range(0, 2),
                       ($urandom_range(0, 3) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
